count_range_ctrl: RTL and testbench

Control stage that drives the 4-bit synchronous counter (enable, mode, parallel data) and consumes its output Q, turning it into a programmable-range counter that cycles lo..hi. It latches a range on a start command, preloads the counter, issues a reload whenever Q reaches the upper bound, and counts and flags wrap events and range faults. It is instantiated next to the counter, sharing its clock and reset.

---
 rtl/count_range_ctrl.sv | 150 +++++++++++++++
 tb/tb_count_range_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/count_range_ctrl.sv
// Control stage for an external 4-bit loadable counter: keeps its output q cycling
// through a programmed lo..hi range, counting wraps and flagging range faults.
module count_range_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic [3:0] lo,
    input  logic [3:0] hi,
    input  logic [3:0] q,
    output logic       cnt_enb,
    output logic       cnt_modo,
    output logic [3:0] cnt_data,
    output logic       wrap,
    output logic [7:0] wraps,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] lo_r;
    logic [3:0] hi_r;
    logic [7:0] wraps_r;
    logic       err_r;

    logic       range_ok_s;
    logic       at_hi_s;
    logic       fault_s;
    logic       accept_s;

    assign range_ok_s = (lo <= hi);
    assign accept_s   = (state_r == IDLE) && start && range_ok_s;
    assign at_hi_s    = (q == hi_r);
    assign fault_s    = (q < lo_r) || (q > hi_r);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; LOAD always lasts exactly one cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && range_ok_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Counter control outputs; a range fault reloads lo just like a wrap but is not counted
    always_comb begin
        cnt_enb  = 1'b0;
        cnt_modo = 1'b0;
        wrap     = 1'b0;
        case (state_r)
            IDLE: begin
                cnt_enb  = 1'b0;
                cnt_modo = 1'b0;
                wrap     = 1'b0;
            end
            LOAD: begin
                cnt_enb  = 1'b1;
                cnt_modo = 1'b1;
                wrap     = 1'b0;
            end
            RUN: begin
                cnt_enb = 1'b1;
                if (at_hi_s) begin
                    cnt_modo = 1'b1;
                    wrap     = 1'b1;
                end else if (fault_s) begin
                    cnt_modo = 1'b1;
                    wrap     = 1'b0;
                end else begin
                    cnt_modo = 1'b0;
                    wrap     = 1'b0;
                end
            end
            default: begin
                cnt_enb  = 1'b0;
                cnt_modo = 1'b0;
                wrap     = 1'b0;
            end
        endcase
    end

    assign cnt_data = lo_r;
    assign busy     = (state_r != IDLE);
    assign wraps    = wraps_r;
    assign err      = err_r;

    // Range latch, saturating wrap count and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_r    <= 4'd0;
            hi_r    <= 4'd15;
            wraps_r <= 8'd0;
            err_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                lo_r    <= lo;
                hi_r    <= hi;
                wraps_r <= 8'd0;
                err_r   <= 1'b0;
            end else if ((state_r == IDLE) && start) begin
                err_r <= 1'b1;
            end else if (state_r == RUN) begin
                if (at_hi_s) begin
                    if (wraps_r != 8'd255) begin
                        wraps_r <= wraps_r + 8'd1;
                    end
                end else if (fault_s) begin
                    err_r <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_count_range_ctrl.sv
// Directed bench for count_range_ctrl with a behavioural model of the 4-bit counter
// closing the loop; q can be overridden to emulate a counter disturbance.
module tb_count_range_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] lo = 4'd0;
    logic [3:0] hi = 4'd0;
    logic [3:0] q;
    logic       cnt_enb;
    logic       cnt_modo;
    logic [3:0] cnt_data;
    logic       wrap;
    logic [7:0] wraps;
    logic       busy;
    logic       err;

    logic [3:0] q_cnt = 4'd0;
    logic       disturb = 1'b0;
    logic [3:0] disturb_val = 4'd0;

    int checks = 0;
    int passed = 0;

    count_range_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .lo       (lo),
        .hi       (hi),
        .q        (q),
        .cnt_enb  (cnt_enb),
        .cnt_modo (cnt_modo),
        .cnt_data (cnt_data),
        .wrap     (wrap),
        .wraps    (wraps),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    assign q = disturb ? disturb_val : q_cnt;

    // Counter model: load or increment only while enabled
    always @(posedge clk) begin
        if (cnt_enb) begin
            if (cnt_modo) q_cnt <= cnt_data;
            else          q_cnt <= q + 4'd1;
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({cnt_enb, cnt_modo, cnt_data, wrap, busy, wraps, err} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL reset_outputs: got enb=%0d modo=%0d data=%0d wrap=%0d busy=%0d wraps=%0d err=%0d expected all 0",
                     cnt_enb, cnt_modo, cnt_data, wrap, busy, wraps, err);
        end else passed++;
        rst = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || cnt_enb !== 1'b0) begin
            $display("FAIL idle_after_reset: got busy=%0d enb=%0d expected 0 0", busy, cnt_enb);
        end else passed++;
    endtask

    task automatic test_basic_run;
        int bad;
        lo = 4'd3; hi = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, cnt_enb, cnt_modo, wrap, cnt_data} !== {1'b1, 1'b1, 1'b1, 1'b0, 4'd3}) begin
            $display("FAIL load_cycle: got busy=%0d enb=%0d modo=%0d wrap=%0d data=%0d expected 1 1 1 0 3",
                     busy, cnt_enb, cnt_modo, wrap, cnt_data);
        end else passed++;
        step();
        checks++;
        if (q !== 4'd3 || cnt_modo !== 1'b0 || wrap !== 1'b0) begin
            $display("FAIL first_run: got q=%0d modo=%0d wrap=%0d expected 3 0 0", q, cnt_modo, wrap);
        end else passed++;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (q !== 4'(3 + (i % 4)) || wrap !== ((i % 4) == 3)) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL run_3_6_sequence: got %0d bad cycles expected 0", bad);
        end else passed++;
        checks++;
        if (wraps !== 8'd3 || err !== 1'b0 || q !== 4'd3) begin
            $display("FAIL three_periods: got wraps=%0d err=%0d q=%0d expected 3 0 3", wraps, err, q);
        end else passed++;
    endtask

    task automatic test_stop;
        // Entered in RUN with q=3; invalid then valid starts must both be ignored while busy
        start = 1'b1; lo = 4'd9; hi = 4'd2;
        step();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || q !== 4'd4) begin
            $display("FAIL start_ignored_bad: got err=%0d busy=%0d q=%0d expected 0 1 4", err, busy, q);
        end else passed++;
        lo = 4'd0; hi = 4'd15;
        step();
        start = 1'b0;
        checks++;
        if (cnt_data !== 4'd3 || q !== 4'd5 || wraps !== 8'd3) begin
            $display("FAIL start_ignored_good: got data=%0d q=%0d wraps=%0d expected 3 5 3", cnt_data, q, wraps);
        end else passed++;
        step();
        checks++;
        if (q !== 4'd6 || wrap !== 1'b1) begin
            $display("FAIL at_hi_before_stop: got q=%0d wrap=%0d expected 6 1", q, wrap);
        end else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if ({busy, cnt_enb, wrap, q, wraps} !== {1'b0, 1'b0, 1'b0, 4'd3, 8'd4}) begin
            $display("FAIL stop_on_wrap: got busy=%0d enb=%0d wrap=%0d q=%0d wraps=%0d expected 0 0 0 3 4",
                     busy, cnt_enb, wrap, q, wraps);
        end else passed++;
        step();
        step();
        checks++;
        if (q !== 4'd3 || busy !== 1'b0 || wraps !== 8'd4) begin
            $display("FAIL frozen_after_stop: got q=%0d busy=%0d wraps=%0d expected 3 0 4", q, busy, wraps);
        end else passed++;
    endtask

    task automatic test_bad_range;
        int bad;
        lo = 4'd9; hi = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0 || cnt_data !== 4'd3) begin
            $display("FAIL bad_range: got err=%0d busy=%0d data=%0d expected 1 0 3", err, busy, cnt_data);
        end else passed++;
        lo = 4'd0; hi = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1 || wraps !== 8'd0) begin
            $display("FAIL err_cleared: got err=%0d busy=%0d wraps=%0d expected 0 1 0", err, busy, wraps);
        end else passed++;
        step();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (q !== 4'(i % 2) || wrap !== ((i % 2) == 1)) bad++;
            step();
        end
        checks++;
        if (bad != 0 || wraps !== 8'd3) begin
            $display("FAIL run_0_1: got %0d bad cycles wraps=%0d expected 0 3", bad, wraps);
        end else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || q !== 4'd1) begin
            $display("FAIL stop_0_1: got busy=%0d q=%0d expected 0 1", busy, q);
        end else passed++;
    endtask

    task automatic test_equal_bounds;
        int bad;
        lo = 4'd5; hi = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (q !== 4'd5 || wrap !== 1'b1 || cnt_modo !== 1'b1 || wraps !== 8'((i < 255) ? i : 255)) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            $display("FAIL equal_bounds_run: got %0d bad cycles expected 0", bad);
        end else passed++;
        checks++;
        if (wraps !== 8'd255) begin
            $display("FAIL wraps_saturate: got %0d expected 255", wraps);
        end else passed++;
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_fault_and_reset;
        lo = 4'd3; hi = 4'd6; start = 1'b1;
        step();
        start = 1'b0;
        step();
        for (int i = 0; i < 5; i++) step();
        checks++;
        if (q !== 4'd4 || wraps !== 8'd1 || err !== 1'b0) begin
            $display("FAIL pre_fault: got q=%0d wraps=%0d err=%0d expected 4 1 0", q, wraps, err);
        end else passed++;
        disturb_val = 4'd12;
        disturb = 1'b1;
        #1;
        checks++;
        if (cnt_modo !== 1'b1 || wrap !== 1'b0 || cnt_enb !== 1'b1) begin
            $display("FAIL fault_reload: got modo=%0d wrap=%0d enb=%0d expected 1 0 1", cnt_modo, wrap, cnt_enb);
        end else passed++;
        step();
        disturb = 1'b0;
        #1;
        checks++;
        if (q !== 4'd3 || err !== 1'b1 || wraps !== 8'd1) begin
            $display("FAIL after_fault: got q=%0d err=%0d wraps=%0d expected 3 1 1", q, err, wraps);
        end else passed++;
        step();
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cnt_enb, cnt_modo, cnt_data, wrap, busy, wraps, err} !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0, 1'b0}) begin
            $display("FAIL async_reset: got enb=%0d modo=%0d data=%0d wrap=%0d busy=%0d wraps=%0d err=%0d expected all 0",
                     cnt_enb, cnt_modo, cnt_data, wrap, busy, wraps, err);
        end else passed++;
        step();
        checks++;
        if (q !== 4'd4 || busy !== 1'b0) begin
            $display("FAIL hold_in_reset: got q=%0d busy=%0d expected 4 0", q, busy);
        end else passed++;
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_run();
        test_stop();
        test_bad_range();
        test_equal_bounds();
        test_fault_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
